// File: rtl/operand_read_pkg.sv
// Shared constants and the ID/EX operand bundle for the operand read stage.
package operand_read_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } id_ex_t;

endpackage

// File: rtl/operand_read_regfile_2r1w.sv
// Architectural integer register file: two combinational read ports with
// same-cycle writeback bypass, one write port, x0 hardwired to zero.
module regfile_2r1w
    import operand_read_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int DEPTH  = NREG,
    parameter int ADDR_W = AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    // x0 check first so a dropped x0 write can never leak through the bypass
    assign rd1 = (ra1 == '0)          ? '0 :
                 (we && wa == ra1)    ? wd : regs[ra1];
    assign rd2 = (ra2 == '0)          ? '0 :
                 (we && wa == ra2)    ? wd : regs[ra2];

endmodule

// File: rtl/operand_read.sv
// ID stage operand read: register file lookup with writeback bypass,
// registered into the ID/EX boundary under flush/stall control.
module operand_read
    import operand_read_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_RegWrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_write_data,
    output logic            out_valid,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    id_ex_t          id_ex;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    // A stalled entry re-reads its own sources so it never holds stale data
    assign ra1 = stall ? id_ex.rs1 : rs1;
    assign ra2 = stall ? id_ex.rs2 : rs2;

    regfile_2r1w #(
        .DATA_W (XLEN),
        .DEPTH  (NREG),
        .ADDR_W (AW)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (wb_RegWrite),
        .wa    (wb_rd),
        .wd    (wb_write_data),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex <= '0;
        end else if (flush) begin
            id_ex <= '0;
        end else if (stall) begin
            id_ex.rs1_data <= rd1;
            id_ex.rs2_data <= rd2;
        end else begin
            id_ex.valid    <= in_valid;
            id_ex.rs1      <= rs1;
            id_ex.rs2      <= rs2;
            id_ex.rd       <= rd_in;
            id_ex.rs1_data <= rd1;
            id_ex.rs2_data <= rd2;
        end
    end

    assign out_valid = id_ex.valid;
    assign out_rs1   = id_ex.rs1;
    assign out_rs2   = id_ex.rs2;
    assign out_rd    = id_ex.rd;
    assign rs1_data  = id_ex.rs1_data;
    assign rs2_data  = id_ex.rs2_data;

endmodule

// File: tb/tb_operand_read.sv
// Scoreboard bench for operand_read: driver pushes model predictions,
// monitor pops and compares one ID/EX snapshot per clock.
module tb_operand_read;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  rs1, rs2, rd_in;
    logic        stall, flush;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_write_data;
    logic        out_valid;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [63:0] rs1_data, rs2_data;

    typedef struct {
        logic        v;
        logic [4:0]  r1, r2, rd;
        logic [63:0] d1, d2;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mregs [32];
    exp_t        m;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    operand_read dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd_in         (rd_in),
        .stall         (stall),
        .flush         (flush),
        .wb_RegWrite   (wb_RegWrite),
        .wb_rd         (wb_rd),
        .wb_write_data (wb_write_data),
        .out_valid     (out_valid),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        m = '{v: 1'b0, r1: 5'd0, r2: 5'd0, rd: 5'd0, d1: 64'd0, d2: 64'd0};
    endtask

    function automatic logic [63:0] val(input logic [4:0] i, input logic we,
                                        input logic [4:0] wa,
                                        input logic [63:0] wd);
        if (i == 5'd0) return 64'd0;
        if (we && wa == i) return wd;
        return mregs[i];
    endfunction

    // Called at a negedge: drive one cycle of inputs and predict the capture
    task automatic step(input logic iv, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic st, input logic fl,
                        input logic we, input logic [4:0] wa,
                        input logic [63:0] wd);
        in_valid = iv; rs1 = a; rs2 = b; rd_in = d;
        stall = st; flush = fl;
        wb_RegWrite = we; wb_rd = wa; wb_write_data = wd;
        if (fl) begin
            m = '{v: 1'b0, r1: 5'd0, r2: 5'd0, rd: 5'd0, d1: 64'd0, d2: 64'd0};
        end else if (st) begin
            m.d1 = val(m.r1, we, wa, wd);
            m.d2 = val(m.r2, we, wa, wd);
        end else begin
            m = '{v: iv, r1: a, r2: b, rd: d,
                  d1: val(a, we, wa, wd), d2: val(b, we, wa, wd)};
        end
        sb.push_back(m);
        if (we && wa != 5'd0) mregs[wa] = wd;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out_valid", {63'd0, out_valid}, {63'd0, e.v});
            chk("out_rs1", {59'd0, out_rs1}, {59'd0, e.r1});
            chk("out_rs2", {59'd0, out_rs2}, {59'd0, e.r2});
            chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
            chk("rs1_data", rs1_data, e.d1);
            chk("rs2_data", rs2_data, e.d2);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_idx"}, {49'd0, out_rs1, out_rs2, out_rd}, 64'd0);
        chk({tag, "_d1"}, rs1_data, 64'd0);
        chk({tag, "_d2"}, rs2_data, 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 0; rs1 = 0; rs2 = 0; rd_in = 0;
        stall = 0; flush = 0;
        wb_RegWrite = 0; wb_rd = 0; wb_write_data = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        // reset then read
        step(1, 5'd5, 5'd0, 5'd1, 0, 0, 0, 5'd0, 64'd0);
        // write then read
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'd7, 64'h1234_5678_9ABC_DEF0);
        step(1, 5'd7, 5'd0, 5'd2, 0, 0, 0, 5'd0, 64'd0);
        // same-cycle bypass on both ports
        step(1, 5'd3, 5'd3, 5'd4, 0, 0, 1, 5'd3, 64'hDEAD);
        // x0 protection, including same-cycle read
        step(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'd0, 64'hFFFF);
        step(1, 5'd0, 5'd3, 5'd0, 0, 0, 0, 5'd0, 64'd0);
        // stall refresh
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'd9, 64'h10);
        step(1, 5'd1, 5'd9, 5'd6, 0, 0, 0, 5'd0, 64'd0);
        step(1, 5'd2, 5'd2, 5'd2, 1, 0, 1, 5'd9, 64'h20);
        step(1, 5'd2, 5'd2, 5'd2, 1, 0, 0, 5'd0, 64'd0);
        // flush wins over stall
        step(1, 5'd7, 5'd3, 5'd8, 1, 1, 0, 5'd0, 64'd0);

        for (int n = 0; n < 1500; n++) begin
            logic [4:0] a, b, wa;
            logic       narrow;
            narrow = ($urandom_range(0, 3) == 0);
            a  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            b  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            step(1'($urandom), a, b, 5'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) < 3), wa,
                 {$urandom, $urandom});
        end

        // async reset mid-cycle with a write in flight
        step(1, 5'd7, 5'd3, 5'd5, 0, 0, 1, 5'd7, 64'hAAAA);
        wb_RegWrite = 1; wb_rd = 5'd12; wb_write_data = 64'h5555;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step(1, 5'd12, 5'd7, 5'd1, 0, 0, 0, 5'd0, 64'd0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 64'd0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_read.md
Name: operand_read

Overview:
- ID-stage consumer of the writeback result bus: holds the 32-entry architectural integer register file and accepts writes from writeback.
- Reads two source operands, with same-cycle writeback bypass, for the instruction being decoded.
- Registers the operands into the ID/EX boundary with valid, stall and flush control.
- Sits between decode and execute; writeback drives its write port.

Parameters:
- XLEN, 64, data width of registers and the writeback bus
- NREG, 32, number of architectural registers (x0 hardwired to zero)
- AW, 5, register index width (log2 NREG)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present in ID
- rs1  in  AW  source register 1 index
- rs2  in  AW  source register 2 index
- rd_in  in  AW  destination index of the decoded instruction, passed through
- stall  in  1  hold the ID/EX contents
- flush  in  1  squash the ID/EX contents (bubble)
- wb_RegWrite  in  1  writeback write enable
- wb_rd  in  AW  writeback destination index
- wb_write_data  in  XLEN  writeback data (ALU result or load data)
- out_valid  out  1  ID/EX entry valid
- out_rs1  out  AW  registered rs1 index
- out_rs2  out  AW  registered rs2 index
- out_rd  out  AW  registered destination index
- rs1_data  out  XLEN  registered operand 1
- rs2_data  out  XLEN  registered operand 2

Behaviour:
- Reset: reset low asynchronously clears all NREG registers and every output to 0. Release is synchronous to clk.
- Write port:
  - At posedge clk, if wb_RegWrite=1 and wb_rd!=0, reg[wb_rd] <= wb_write_data.
  - Writes to x0 are dropped; reg[0] is always 0.
- Read path (combinational, internal):
  - val(i) = 0 if i==0.
  - Otherwise val(i) = wb_write_data if wb_RegWrite && wb_rd==i.
  - Otherwise val(i) = reg[i].
- ID/EX update at posedge clk, priority flush > stall > normal:
  - flush=1: out_valid<=0; out_rs1, out_rs2, out_rd <= 0; rs1_data, rs2_data <= 0. Applies regardless of stall.
  - stall=1, flush=0: out_valid, out_rs1, out_rs2, out_rd hold. rs1_data<=val(out_rs1) and rs2_data<=val(out_rs2), so a held instruction picks up writebacks that land during the stall. No stale operands.
  - Normal: out_valid<=in_valid; out_rs1<=rs1; out_rs2<=rs2; out_rd<=rd_in; rs1_data<=val(rs1); rs2_data<=val(rs2).
  - in_valid=0 still captures indices and data; consumers qualify with out_valid.
- Latency: operands appear 1 cycle after rs1/rs2 are presented. A writeback in the same cycle as the read is visible in that capture.
- Simultaneous events:
  - rs1==rs2==wb_rd: both outputs take the bypassed value.
  - wb_rd==0 with wb_RegWrite=1: no write; reads of x0 return 0.
- Reset mid-stall or mid-write: reset wins. The register file is cleared and the in-flight write is lost.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared package: XLEN, NREG and AW constants; the ID/EX operand struct typedef {valid, rs1, rs2, rd, rs1_data, rs2_data}.
- One sub-module, regfile_2r1w:
  - array, write port, x0 masking and writeback bypass;
  - two combinational read ports, one write port.
- operand_read adds the ID/EX register and the stall/flush logic.

Test Plan:
- Reset then read: reset low then high, rs1=5, rs2=0, in_valid=1 -> next cycle rs1_data=0, rs2_data=0, out_valid=1.
- Write then read: wb_RegWrite=1, wb_rd=7, wb_write_data=0x1234_5678_9ABC_DEF0; next cycle rs1=7 -> rs1_data=0x123456789ABCDEF0.
- Same-cycle bypass: wb writes x3=0xDEAD while rs1=3 and rs2=3 -> both outputs 0xDEAD next cycle.
- x0 protection: wb_RegWrite=1, wb_rd=0, data=0xFFFF; then read rs1=0 -> rs1_data=0, including the same-cycle read.
- Stall refresh: capture rs2=9 (value 0x10); stall=1 for 2 cycles while wb writes x9=0x20 -> out_rs2 stays 9 and rs2_data becomes 0x20 the cycle after the write.
- Flush priority: stall=1 and flush=1 together -> out_valid=0 and all outputs 0 next cycle; an async reset asserted mid-cycle clears outputs immediately.
